// File: rtl/keysw_io_responder.sv
// KEY/SW memory-mapped responder: 2-flop sync, per-device debounce, sticky RDY/OR status.
// Define KEYSW_IRQ_EN to add the registered irq output.
module keysw_dev #(
    parameter int          W        = 4,
    parameter bit          INVERT   = 1'b0,
    parameter logic [15:0] DEBOUNCE = 16'd50000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] raw,
    input  logic         rd_data,
    input  logic         wr_ctrl,
    input  logic         wr_or,
    input  logic         wr_ie,
    output logic [W-1:0] stable,
    output logic         rdy,
    output logic         ovr,
    output logic         ie
);
    localparam int STAGES = 2;

    logic [W-1:0]    s1, s2, prev, sample;
    logic [15:0]     cnt;
    logic [STAGES:0] vld_pipe;
    logic            ev;

    assign sample = INVERT ? ~s2 : s2;
    assign ev = vld_pipe[STAGES] && (sample == prev) && (sample != stable)
                && (cnt == DEBOUNCE - 16'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1       <= '0;
            s2       <= '0;
            prev     <= '0;
            stable   <= '0;
            cnt      <= '0;
            vld_pipe <= '0;
            rdy      <= 1'b0;
            ovr      <= 1'b0;
            ie       <= 1'b0;
        end else begin
            s1       <= raw;
            s2       <= s1;
            prev     <= sample;
            vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
            // First real sample seeds the stable value silently.
            if (!vld_pipe[STAGES]) begin
                if (vld_pipe[STAGES-1])
                    stable <= sample;
                cnt <= '0;
            end else if (sample != prev || sample == stable) begin
                cnt <= '0;
            end else if (cnt == DEBOUNCE - 16'd1) begin
                stable <= sample;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 16'd1;
            end

            if (ev)
                rdy <= 1'b1;
            else if (rd_data)
                rdy <= 1'b0;

            // Event beats a concurrent OR-clear; a concurrent data read suppresses overrun.
            if (ev && rdy && !rd_data)
                ovr <= 1'b1;
            else if (wr_ctrl && !wr_or)
                ovr <= 1'b0;

            if (wr_ctrl)
                ie <= wr_ie;
        end
    end
endmodule

module keysw_io_responder #(
    parameter int                DBITS    = 32,
    parameter logic [DBITS-1:0]  ADDRKEY  = 32'hFFFFF080,
    parameter logic [DBITS-1:0]  ADDRSW   = 32'hFFFFF090,
    parameter logic [15:0]       DEBOUNCE = 16'd50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] addr,
    input  logic [DBITS-1:0] wrdata,
    input  logic             we,
    input  logic             re,
    output logic [DBITS-1:0] rddata,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW
`ifdef KEYSW_IRQ_EN
    ,
    output logic             irq
`endif
);
    localparam logic [DBITS-1:0] KCTRL_A = ADDRKEY + DBITS'(4);
    localparam logic [DBITS-1:0] SCTRL_A = ADDRSW + DBITS'(4);

    logic             hit_kdata, hit_kctrl, hit_sdata, hit_sctrl;
    logic [3:0]       key_stable;
    logic [9:0]       sw_stable;
    logic             k_rdy, k_ovr, k_ie, s_rdy, s_ovr, s_ie;
    logic [DBITS-1:0] rd_next;
    logic             unused_bits;

    assign hit_kdata = addr[DBITS-1:2] == ADDRKEY[DBITS-1:2];
    assign hit_kctrl = addr[DBITS-1:2] == KCTRL_A[DBITS-1:2];
    assign hit_sdata = addr[DBITS-1:2] == ADDRSW[DBITS-1:2];
    assign hit_sctrl = addr[DBITS-1:2] == SCTRL_A[DBITS-1:2];
    assign unused_bits = ^{addr[1:0], wrdata[DBITS-1:5], wrdata[3], wrdata[1:0]};

    keysw_dev #(.W(4), .INVERT(1'b1), .DEBOUNCE(DEBOUNCE)) u_key (
        .clk     (clk),
        .reset   (reset),
        .raw     (KEY),
        .rd_data (re && hit_kdata),
        .wr_ctrl (we && hit_kctrl),
        .wr_or   (wrdata[2]),
        .wr_ie   (wrdata[4]),
        .stable  (key_stable),
        .rdy     (k_rdy),
        .ovr     (k_ovr),
        .ie      (k_ie)
    );

    keysw_dev #(.W(10), .INVERT(1'b0), .DEBOUNCE(DEBOUNCE)) u_sw (
        .clk     (clk),
        .reset   (reset),
        .raw     (SW),
        .rd_data (re && hit_sdata),
        .wr_ctrl (we && hit_sctrl),
        .wr_or   (wrdata[2]),
        .wr_ie   (wrdata[4]),
        .stable  (sw_stable),
        .rdy     (s_rdy),
        .ovr     (s_ovr),
        .ie      (s_ie)
    );

    always_comb begin
        rd_next = '0;
        if (re) begin
            if (hit_kdata)
                rd_next = DBITS'(key_stable);
            else if (hit_kctrl)
                rd_next = DBITS'({k_ie, 1'b0, k_ovr, 1'b0, k_rdy});
            else if (hit_sdata)
                rd_next = DBITS'(sw_stable);
            else if (hit_sctrl)
                rd_next = DBITS'({s_ie, 1'b0, s_ovr, 1'b0, s_rdy});
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            rddata <= '0;
        else
            rddata <= rd_next;
    end

`ifdef KEYSW_IRQ_EN
    always_ff @(posedge clk) begin
        if (reset)
            irq <= 1'b0;
        else
            irq <= (k_rdy & k_ie) | (s_rdy & s_ie);
    end
`endif
endmodule
